// File: rtl/val2_seq_ctrl_pkg.sv
// Shared types, field positions and helpers for the Val2 sequencer.
// Imported by the interface-facing top and its step shifter.
package val2_pkg;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam int SHAMT_HI = 11;
  localparam int SHAMT_LO = 7;
  localparam int TYPE_HI  = 6;
  localparam int TYPE_LO  = 5;
  localparam int ROT_HI   = 11;
  localparam int ROT_LO   = 8;

  function automatic logic [31:0] ror32(
    input logic [31:0] x,
    input logic [4:0]  n
  );
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [31:0] sext12(
    input logic [11:0] v
  );
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/val2_seq_ctrl_if.sv
// Request/response handshake bundle for the Val2 sequencer.
// master = pipeline side, slave = sequencer side.
interface val2_seq_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_mem;
  logic        req_imm;
  logic [11:0] req_shift_operand;
  logic [31:0] req_rm;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_val2;

  modport master (
    output req_valid,
    output req_mem,
    output req_imm,
    output req_shift_operand,
    output req_rm,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_val2
  );

  modport slave (
    input  req_valid,
    input  req_mem,
    input  req_imm,
    input  req_shift_operand,
    input  req_rm,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_val2
  );

endinterface

// File: rtl/val2_seq_ctrl_step_shifter.sv
// Combinational 32-bit shift of 0..STEP bits for one SHIFT cycle.
// Repeated application composes into the full single-shot shift.
module val2_step_shifter
  import val2_pkg::*;
#(
  parameter int STEP = 4,
  parameter int AW   = $clog2(STEP + 1)
) (
  input  logic [31:0]   din,
  input  shift_type_e   typ,
  input  logic [AW-1:0] amt,
  output logic [31:0]   dout
);

  logic signed [31:0] din_s;
  logic [5:0]         back;

  assign din_s = din;
  assign back  = 6'd32 - 6'(amt);

  always_comb begin
    dout = din;
    unique case (typ)
      LSL: dout = din << amt;
      LSR: dout = din >> amt;
      // sign comes from the current bit 31, so it survives every step
      ASR: dout = din_s >>> amt;
      ROR: dout = (din >> amt) | (din << back);
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/val2_seq_ctrl.sv
// Multi-cycle Val2 sequencer: memory offset, rotated immediate,
// or register shifted iteratively STEP bits per cycle.
module val2_seq_ctrl
  import val2_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  val2_seq_ctrl_if.slave bus,
  output logic          busy
);

  localparam int AW = $clog2(STEP + 1);
  localparam logic [4:0] STEP5 = 5'(STEP);

  state_e      state_q, state_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  rem_q, rem_d;
  shift_type_e typ_q, typ_d;

  logic          accept;
  logic          last_step;
  logic          is_shift;
  logic [4:0]    amt_in;
  shift_type_e   typ_in;
  logic [4:0]    rot_in;
  logic [AW-1:0] step_amt;
  logic [31:0]   step_out;

  assign amt_in = bus.req_shift_operand[SHAMT_HI:SHAMT_LO];
  assign typ_in = shift_type_e'(bus.req_shift_operand[TYPE_HI:TYPE_LO]);
  assign rot_in = {bus.req_shift_operand[ROT_HI:ROT_LO], 1'b0};
  assign is_shift = !bus.req_mem && !bus.req_imm;

  assign accept    = (state_q == IDLE) && bus.req_valid && !flush;
  assign last_step = (rem_q <= STEP5);
  assign step_amt  = last_step ? AW'(rem_q) : AW'(STEP);

  val2_step_shifter #(
    .STEP (STEP),
    .AW   (AW)
  ) u_step (
    .din  (res_q),
    .typ  (typ_q),
    .amt  (step_amt),
    .dout (step_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      rem_q   <= '0;
      typ_q   <= LSL;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      typ_q   <= typ_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            state_d = (is_shift && amt_in != 5'd0) ? SHIFT : DONE;
          end
        end
        SHIFT: if (last_step) state_d = DONE;
        DONE:  if (bus.resp_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    res_d = res_q;
    rem_d = rem_q;
    typ_d = typ_q;
    if (flush) begin
      rem_d = '0;
    end else if (accept) begin
      rem_d = '0;
      typ_d = typ_in;
      // mem form outranks imm when both are set
      if (bus.req_mem) begin
        res_d = sext12(bus.req_shift_operand);
      end else if (bus.req_imm) begin
        res_d = ror32({24'b0, bus.req_shift_operand[7:0]}, rot_in);
      end else begin
        res_d = bus.req_rm;
        rem_d = amt_in;
      end
    end else if (state_q == SHIFT) begin
      res_d = step_out;
      rem_d = rem_q - 5'(step_amt);
    end
  end

  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == DONE);
    bus.resp_val2  = res_q;
    busy           = (state_q != IDLE);
  end

endmodule

// File: tb/tb_val2_seq_ctrl.sv
// Self-checking bench for val2_seq_ctrl: vector table, hand
// sequences for backpressure/flush/reset, and a random model run.
module tb_val2_seq_ctrl;

  localparam int STEP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy;

  int errors = 0;
  int checks = 0;

  val2_seq_ctrl_if bus ();

  val2_seq_ctrl #(.STEP(STEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic        i;
    logic [11:0] so;
    logic [31:0] rm;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic m, input logic i,
                                        input logic [11:0] so,
                                        input logic [31:0] rm);
    logic signed [31:0] s;
    logic [63:0] d;
    int n;
    if (m) begin
      s = $signed(so);
      return s;
    end
    if (i) begin
      d = {24'b0, so[7:0], 24'b0, so[7:0]};
      n = 2 * int'(so[11:8]);
      d = d >> n;
      return d[31:0];
    end
    n = int'(so[11:7]);
    case (so[6:5])
      2'b00: return rm << n;
      2'b01: return rm >> n;
      2'b10: begin
        s = rm;
        s = s >>> n;
        return s;
      end
      default: begin
        d = {rm, rm} >> n;
        return d[31:0];
      end
    endcase
  endfunction

  function automatic int model_lat(input logic m, input logic i,
                                   input logic [11:0] so);
    int n;
    n = int'(so[11:7]);
    if (m || i || n == 0) return 1;
    return (n + STEP - 1) / STEP + 1;
  endfunction

  task automatic run_txn(input logic m, input logic i,
                         input logic [11:0] so, input logic [31:0] rm,
                         input int hold,
                         output logic [31:0] val, output int lat);
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_mem = m;
    bus.req_imm = i;
    bus.req_shift_operand = so;
    bus.req_rm = rm;
    tick();
    lat = 1;
    bus.req_valid = 1'b0;
    bus.req_mem = 1'($urandom);
    bus.req_imm = 1'($urandom);
    bus.req_shift_operand = 12'($urandom);
    bus.req_rm = $urandom;
    while (!bus.resp_valid && lat < 64) begin
      tick();
      lat++;
    end
    val = bus.resp_val2;
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("hold_val", bus.resp_val2, val);
      chk("hold_flags", {30'd0, bus.resp_valid, bus.req_ready}, 32'd2);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk("release_idle", {30'd0, busy, bus.req_ready}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int lat;
    int flush_seen;

    tbl[0]  = '{1'b1, 1'b0, 12'hFFC, 32'h0,         32'hFFFF_FFFC, 1};
    tbl[1]  = '{1'b1, 1'b0, 12'h07F, 32'h0,         32'h0000_007F, 1};
    tbl[2]  = '{1'b0, 1'b1, 12'h13F, 32'h0,         32'hC000_000F, 1};
    tbl[3]  = '{1'b0, 1'b1, 12'h4FF, 32'h0,         32'hFF00_0000, 1};
    tbl[4]  = '{1'b0, 1'b1, 12'h0AB, 32'h0,         32'h0000_00AB, 1};
    tbl[5]  = '{1'b0, 1'b0, 12'h280, 32'h1,         32'h0000_0020, 3};
    tbl[6]  = '{1'b0, 1'b0, 12'hFC0, 32'h8000_0000, 32'hFFFF_FFFF, 9};
    tbl[7]  = '{1'b0, 1'b0, 12'hFA0, 32'h8000_0000, 32'h0000_0001, 9};
    tbl[8]  = '{1'b0, 1'b0, 12'h270, 32'h1234_5678, 32'h8123_4567, 2};
    tbl[9]  = '{1'b0, 1'b0, 12'h070, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
    tbl[10] = '{1'b0, 1'b0, 12'h05F, 32'h8000_0001, 32'h8000_0001, 1};
    tbl[11] = '{1'b1, 1'b1, 12'h800, 32'h1234_5678, 32'hFFFF_F800, 1};
    tbl[12] = '{1'b0, 1'b0, 12'h240, 32'h8765_4321, 32'hF876_5432, 2};
    tbl[13] = '{1'b0, 1'b0, 12'h420, 32'hF000_0000, 32'h00F0_0000, 3};
    tbl[14] = '{1'b0, 1'b0, 12'hFE0, 32'h0000_0001, 32'h0000_0002, 9};

    bus.req_valid = 1'b0;
    bus.req_mem = 1'b0;
    bus.req_imm = 1'b0;
    bus.req_shift_operand = '0;
    bus.req_rm = '0;
    bus.resp_ready = 1'b0;

    #12;
    chk("reset_val2", bus.resp_val2, 32'd0);
    chk("reset_flags", {29'd0, busy, bus.resp_valid, bus.req_ready},
        32'd1);
    rst_n = 1'b1;
    tick();

    foreach (tbl[t]) begin
      run_txn(tbl[t].m, tbl[t].i, tbl[t].so, tbl[t].rm, 0, v, lat);
      chk($sformatf("vec%0d_val", t), v, tbl[t].exp);
      chk($sformatf("vec%0d_lat", t), 32'(lat), 32'(tbl[t].lat));
    end

    // backpressure on ROR 4, then a fresh accept right after
    run_txn(1'b0, 1'b0, 12'h270, 32'h1234_5678, 5, v, lat);
    chk("bp_val", v, 32'h8123_4567);
    run_txn(1'b1, 1'b0, 12'h07F, 32'h0, 0, v, lat);
    chk("bp_next_val", v, 32'h0000_007F);

    // flush in the second SHIFT cycle of ASR 31
    bus.req_valid = 1'b1;
    bus.req_shift_operand = 12'hFC0;
    bus.req_rm = 32'h8000_0000;
    tick();
    bus.req_valid = 1'b0;
    chk("fl_busy_shift", 32'(busy), 32'd1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_idle", {29'd0, busy, bus.resp_valid, bus.req_ready}, 32'd1);
    flush_seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.resp_valid) flush_seen++;
    end
    chk("fl_no_resp", 32'(flush_seen), 32'd0);

    // flush wins over a request in IDLE
    bus.req_valid = 1'b1;
    bus.req_mem = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_mem = 1'b0;
    chk("fl_noacc", {29'd0, busy, bus.resp_valid, bus.req_ready}, 32'd1);
    tick();
    chk("fl_noacc2", {30'd0, busy, bus.resp_valid}, 32'd0);

    // flush together with resp_ready in DONE
    bus.req_valid = 1'b1;
    bus.req_mem = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    bus.req_mem = 1'b0;
    chk("fl_done_valid", 32'(bus.resp_valid), 32'd1);
    flush = 1'b1;
    bus.resp_ready = 1'b1;
    tick();
    flush = 1'b0;
    bus.resp_ready = 1'b0;
    chk("fl_done_idle", {29'd0, busy, bus.resp_valid, bus.req_ready},
        32'd1);

    // async reset in the middle of a shift
    bus.req_valid = 1'b1;
    bus.req_shift_operand = 12'hFC0;
    bus.req_rm = 32'h8000_0000;
    tick();
    bus.req_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_flags", {29'd0, busy, bus.resp_valid, bus.req_ready}, 32'd1);
    chk("ar_val2", bus.resp_val2, 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    run_txn(1'b0, 1'b0, 12'h400, 32'h0000_00FF, 0, v, lat);
    chk("ar_lsl8_val", v, 32'h0000_FF00);
    chk("ar_lsl8_lat", 32'(lat), 32'd3);

    // random requests against the reference model
    for (int r = 0; r < 200; r++) begin
      logic m, i;
      logic [11:0] so;
      logic [31:0] rm;
      int kind;
      kind = int'($urandom_range(0, 5));
      m = (kind == 0);
      i = (kind == 1) || (kind == 0 && $urandom_range(0, 1) == 1);
      so = 12'($urandom);
      rm = $urandom;
      run_txn(m, i, so, rm, int'($urandom_range(0, 2)), v, lat);
      chk("rnd_val", v, model(m, i, so, rm));
      chk("rnd_lat", 32'(lat), 32'(model_lat(m, i, so)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
